fifo_sync_flags: RTL and testbench

//  Parametrised single-clock circular-buffer FIFO; successor to the shift-register FIFO.

---
 rtl/fifo_sync_flags.sv | 100 ++++++++++
 tb/tb_fifo_sync_flags.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock circular-buffer FIFO with count, level flags and error pulses
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  // Pointer width covers indices 0..FIFO_DEPTH-1; depth need not be a power of two.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PTR_W-1:0]     LAST_P  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_val;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Acceptance is judged only on the occupancy at the start of the cycle, so a
  // read from a full FIFO never frees room for a same-cycle write (and vice versa).
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  assign wr_ready     = !w_full;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign rd_data      = r_rd_data;
  assign rd_val       = r_rd_val;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage write; the array is not cleared, but nothing is written during reset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, registered read port and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_val    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= (r_rd_ptr == LAST_P) ? '0 : r_rd_ptr + PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_rd_val    <= w_rd_acc;
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - scoreboard bench for fifo_sync_flags (depth 5, AF 4, AE 1)
module tb_fifo_sync_flags;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_val;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  fifo_sync_flags #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .AF_LEVEL(4),
    .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_val(rd_val),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs are examined 1 time unit after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int c, input int ov, input int uf);
    chk({tag, " count"}, count, c);
    chk({tag, " wr_ready"}, wr_ready, (c != DEPTH) ? 1 : 0);
    chk({tag, " almost_full"}, almost_full, (c >= 4) ? 1 : 0);
    chk({tag, " almost_empty"}, almost_empty, (c <= 1) ? 1 : 0);
    chk({tag, " overflow"}, overflow, ov);
    chk({tag, " underflow"}, underflow, uf);
  endtask

  // Monitor: every rd_val pulse must match the oldest expected word.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rd_val) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_val: got data %0h expected no rd_val at %0t", rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    reset = 1'b0;

    // Reset state
    chk_state("reset", 0, 0, 0);
    chk("reset rd_val", rd_val, 0);
    chk("reset rd_data", rd_data, 0);

    // 1: fill to full, then overflow attempt
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(8'h11 + i), 0);
      chk_state("fill", i + 1, 0, 0);
    end
    step(1, 8'h16, 0);
    chk_state("overflow", 5, 1, 0);
    step(0, 8'h00, 0);
    chk_state("overflow_end", 5, 0, 0);

    // 2: drain in order, then underflow attempt
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      step(0, 8'h00, 1);
      chk("drain rd_val", rd_val, 1);
      chk_state("drain", 4 - i, 0, 0);
    end
    step(0, 8'h00, 1);
    chk_state("underflow", 0, 0, 1);
    chk("underflow rd_val", rd_val, 0);
    chk("underflow rd_data_hold", rd_data, 8'h15);
    step(0, 8'h00, 0);
    chk_state("underflow_end", 0, 0, 0);

    // 3: interleaved write/read pairs across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0);
      chk_state("wrap_wr", 1, 0, 0);
      exp_q.push_back(8'(i));
      step(0, 8'h00, 1);
      chk_state("wrap_rd", 0, 0, 0);
    end

    // 4a: full + write + read -> read wins, write rejected
    for (int i = 0; i < 5; i++) step(1, 8'(8'h11 + i), 0);
    exp_q.push_back(8'h11);
    step(1, 8'h77, 1);
    chk_state("full_both", 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h12 + i));
      step(0, 8'h00, 1);
    end
    chk_state("full_both_drained", 0, 0, 0);

    // 4b: empty + write + read -> write wins, no bypass
    step(1, 8'hAA, 1);
    chk_state("empty_both", 1, 0, 1);
    chk("empty_both rd_val", rd_val, 0);
    exp_q.push_back(8'hAA);
    step(0, 8'h00, 1);
    chk("empty_both readback rd_val", rd_val, 1);
    chk_state("empty_both_readback", 0, 0, 0);

    // 5: steady simultaneous traffic at count 3
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back((i < 3) ? 8'(8'h30 + i) : 8'(8'h40 + i - 3));
      step(1, 8'(8'h40 + i), 1);
      chk_state("steady", 3, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h47 + i));
      step(0, 8'h00, 1);
    end
    chk_state("steady_drained", 0, 0, 0);

    // 6: reset mid-operation with requests active
    for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0);
    chk("pre_reset count", count, 3);
    reset = 1'b1;
    step(1, 8'h99, 1);
    reset = 1'b0;
    chk_state("mid_reset", 0, 0, 0);
    chk("mid_reset rd_val", rd_val, 0);
    step(0, 8'h00, 1);
    chk_state("post_reset_read", 0, 0, 1);
    chk("post_reset_read rd_val", rd_val, 0);

    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
